// File: rtl/uart_tx_word_buffer.sv
// Word FIFO feeding a byte-wide UART transmitter: words pushed by the Crypter are
// queued, then serialised one byte at a time through the tx_start / tx_done_tick handshake.
module uart_tx_word_buffer #(
   parameter int WORD_W    = 32,
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WORD_W-1:0]        wr_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     tx_start,
   output logic [7:0]               tx_byte,
   input  logic                     tx_done_tick,
   output logic                     busy,
   output logic [1:0]               state_dbg
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int NBYTES = WORD_W / 8;
   localparam int CNT_W  = $clog2(NBYTES) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   // Handshakes: a word is taken on any cycle with wr_en=1 and either full=0 or a pop
   // in the same cycle, otherwise it is dropped and overflow sticks. Toward UART_TX,
   // tx_start is a one-cycle request; tx_byte stays stable until tx_done_tick returns.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [WORD_W-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                overflow_q, overflow_d;
   logic [WORD_W-1:0]   mem_q [DEPTH];
   logic [WORD_W-1:0]   mem_d [DEPTH];

   logic pop;
   logic push;
   logic last_byte;

   assign empty     = (level_q == '0);
   assign full      = (level_q == FULL_LVL);
   assign last_byte = (cnt_q == LAST_CNT);

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: state_d = WAIT;
         WAIT: begin
            if (tx_done_tick) begin
               if (!last_byte) begin
                  shift_d = (MSB_FIRST != 0) ? (shift_q << 8) : (shift_q >> 8);
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = START;
               end else if (!empty) begin
                  // Chain straight into the next word so no IDLE cycle separates them.
                  pop     = 1'b1;
                  shift_d = mem_q[rd_ptr_q];
                  cnt_d   = '0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      push       = wr_en && (!full || pop);
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      overflow_d = overflow_q || (wr_en && !push);
      level_d    = level_q;
      if (push && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
         level_d = level_q - LVL_W'(1);
      end
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         shift_q    <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: the level counter guards every read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign level     = level_q;
   assign overflow  = overflow_q;
   assign tx_start  = (state_q == START);
   assign tx_byte   = (MSB_FIRST != 0) ? shift_q[WORD_W-1 -: 8] : shift_q[7:0];
   assign busy      = !empty || (state_q != IDLE);
   assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_word_buffer.sv
// Directed bench for uart_tx_word_buffer: MSB-first 32-bit, LSB-first 32-bit and 8-bit builds.
module tb_uart_tx_word_buffer;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // main instance: WORD_W=32, DEPTH=4, MSB_FIRST=1
   logic        wr_en, tx_done_tick, full, empty, overflow, tx_start, busy;
   logic [31:0] wr_data;
   logic [2:0]  level;
   logic [7:0]  tx_byte;
   logic [1:0]  state_dbg;

   // b_: LSB-first build
   logic        b_wr_en, b_tick, b_full, b_empty, b_overflow, b_tx_start, b_busy;
   logic [31:0] b_wr_data;
   logic [2:0]  b_level;
   logic [7:0]  b_tx_byte;
   logic [1:0]  b_state_dbg;

   // c_: one-byte words, two-deep FIFO
   logic        c_wr_en, c_tick, c_full, c_empty, c_overflow, c_tx_start, c_busy;
   logic [7:0]  c_wr_data;
   logic [1:0]  c_level;
   logic [7:0]  c_tx_byte;
   logic [1:0]  c_state_dbg;

   uart_tx_word_buffer #(.WORD_W(32), .DEPTH(4), .MSB_FIRST(1)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
      .level(level), .overflow(overflow), .tx_start(tx_start), .tx_byte(tx_byte),
      .tx_done_tick(tx_done_tick), .busy(busy), .state_dbg(state_dbg));

   uart_tx_word_buffer #(.WORD_W(32), .DEPTH(4), .MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_data(b_wr_data), .full(b_full), .empty(b_empty),
      .level(b_level), .overflow(b_overflow), .tx_start(b_tx_start), .tx_byte(b_tx_byte),
      .tx_done_tick(b_tick), .busy(b_busy), .state_dbg(b_state_dbg));

   uart_tx_word_buffer #(.WORD_W(8), .DEPTH(2), .MSB_FIRST(1)) dut_w8 (
      .clk(clk), .rst(rst), .wr_en(c_wr_en), .wr_data(c_wr_data), .full(c_full), .empty(c_empty),
      .level(c_level), .overflow(c_overflow), .tx_start(c_tx_start), .tx_byte(c_tx_byte),
      .tx_done_tick(c_tick), .busy(c_busy), .state_dbg(c_state_dbg));

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_pass   = 0;
   int start_cnt = 0;
   logic [7:0] exp_q[$];

   always @(negedge clk) if (tx_start === 1'b1) start_cnt++;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1);
   end

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr_en = 1'b0; tx_done_tick = 1'b0; b_wr_en = 1'b0; b_tick = 1'b0; c_wr_en = 1'b0; c_tick = 1'b0;
      repeat (2) step();
      rst = 1'b0;
   endtask

   function automatic logic [31:0] word_of(input int k);
      logic [3:0] n;
      n = 4'(k);
      return {n, 4'h1, n, 4'h2, n, 4'h3, n, 4'h4};
   endfunction

   // Acts as UART_TX for one byte: waits (bounded) for tx_start, holds for dly cycles, ticks.
   task automatic serve_byte(input int dly, output bit ok, output logic [7:0] at_start,
                             output logic [7:0] at_tick);
      for (int i = 0; i < 400 && tx_start !== 1'b1; i++) step();
      ok = (tx_start === 1'b1);
      at_start = tx_byte;
      at_tick  = tx_byte;
      if (!ok) return;
      repeat (dly) step();
      at_tick = tx_byte;
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; wr_en = 1'b1; wr_data = 32'hFFFF_FFFF; tx_done_tick = 1'b1;
      b_wr_en = 1'b0; b_tick = 1'b0; c_wr_en = 1'b0; c_tick = 1'b0;
      repeat (2) step();
      n_checks++; if (tx_start !== 1'b0) $display("FAIL rst_tx_start: got %b want 0", tx_start); else n_pass++;
      n_checks++; if (tx_byte !== 8'h00) $display("FAIL rst_tx_byte: got %h want 00", tx_byte); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (empty !== 1'b1) $display("FAIL rst_empty: got %b want 1", empty); else n_pass++;
      n_checks++; if (full !== 1'b0) $display("FAIL rst_full: got %b want 0", full); else n_pass++;
      n_checks++; if (level !== 3'd0) $display("FAIL rst_level: got %0d want 0", level); else n_pass++;
      n_checks++; if (state_dbg !== 2'd0) $display("FAIL rst_state: got %0d want 0", state_dbg); else n_pass++;
      rst = 1'b0; wr_en = 1'b0; tx_done_tick = 1'b0;
      step();
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_prio_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else n_pass++;
   endtask

   task automatic test_single_word();
      bit ok; logic [7:0] s, t, e; int s0;
      do_reset();
      s0 = start_cnt;
      wr_data = 32'hA1B2C3D4; wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      n_checks++; if (busy !== 1'b1) $display("FAIL lat_busy_n1: got %b want 1", busy); else n_pass++;
      n_checks++; if (tx_start !== 1'b0) $display("FAIL lat_start_n1: got %b want 0", tx_start); else n_pass++;
      step();
      n_checks++; if (tx_start !== 1'b1) $display("FAIL lat_start_n2: got %b want 1", tx_start); else n_pass++;
      exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         serve_byte(10, ok, s, t);
         n_checks++;
         if (!ok || s !== e || t !== e) $display("FAIL single_byte: got start=%h tick=%h ok=%0d want %h", s, t, ok, e);
         else n_pass++;
      end
      n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", busy); else n_pass++;
      repeat (20) step();
      n_checks++;
      if (start_cnt - s0 !== 4) $display("FAIL single_starts: got %0d want 4", start_cnt - s0); else n_pass++;
   endtask

   task automatic test_byte_order();
      logic [7:0] e;
      do_reset();
      b_wr_data = 32'h11223344; b_wr_en = 1'b1;
      step();
      b_wr_en = 1'b0;
      exp_q = '{8'h44, 8'h33, 8'h22, 8'h11};
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         for (int i = 0; i < 400 && b_tx_start !== 1'b1; i++) step();
         n_checks++;
         if (b_tx_start !== 1'b1 || b_tx_byte !== e) $display("FAIL lsb_byte: got start=%b byte=%h want %h", b_tx_start, b_tx_byte, e);
         else n_pass++;
         repeat (3) step();
         b_tick = 1'b1;
         step();
         b_tick = 1'b0;
      end
      n_checks++; if (b_busy !== 1'b0) $display("FAIL lsb_busy_fall: got %b want 0", b_busy); else n_pass++;
   endtask

   task automatic test_overflow();
      bit ok; logic [7:0] s, t, e; int s0;
      do_reset();
      s0 = start_cnt;
      for (int k = 0; k < 6; k++) begin
         wr_data = (k < 5) ? word_of(k) : 32'hDEADBEEF;
         wr_en = 1'b1;
         step();
      end
      wr_en = 1'b0;
      n_checks++; if (full !== 1'b1) $display("FAIL ovf_full: got %b want 1", full); else n_pass++;
      n_checks++; if (level !== 3'd4) $display("FAIL ovf_level: got %0d want 4", level); else n_pass++;
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
      n_checks++; if (tx_byte !== 8'h01) $display("FAIL ovf_inflight: got %h want 01", tx_byte); else n_pass++;
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
      for (int k = 0; k < 5; k++)
         for (int j = (k == 0) ? 1 : 0; j < 4; j++) exp_q.push_back({4'(k), 4'(j + 1)});
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         serve_byte(2, ok, s, t);
         n_checks++;
         if (!ok || s !== e || t !== e) $display("FAIL ovf_byte: got start=%h tick=%h ok=%0d want %h", s, t, ok, e);
         else n_pass++;
      end
      repeat (10) step();
      n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL ovf_busy: got %b want 0", busy); else n_pass++;
      n_checks++;
      if (start_cnt - s0 !== 20) $display("FAIL ovf_starts: got %0d want 20", start_cnt - s0); else n_pass++;
   endtask

   task automatic test_simultaneous();
      bit ok; logic [7:0] s, t, e; int s0;
      do_reset();
      s0 = start_cnt;
      for (int k = 8; k < 13; k++) begin
         wr_data = word_of(k); wr_en = 1'b1;
         step();
      end
      wr_en = 1'b0;
      n_checks++; if (full !== 1'b1 || level !== 3'd4) $display("FAIL sim_prefill: got full=%b level=%0d want 1/4", full, level); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL sim_prefill_ovf: got %b want 0", overflow); else n_pass++;
      n_checks++; if (tx_byte !== 8'h81) $display("FAIL sim_inflight: got %h want 81", tx_byte); else n_pass++;
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
      exp_q = '{8'h82, 8'h83};
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         serve_byte(1, ok, s, t);
         n_checks++;
         if (!ok || s !== e || t !== e) $display("FAIL sim_byte: got start=%h tick=%h ok=%0d want %h", s, t, ok, e);
         else n_pass++;
      end
      for (int i = 0; i < 400 && tx_start !== 1'b1; i++) step();
      n_checks++; if (tx_byte !== 8'h84) $display("FAIL sim_last_byte: got %h want 84", tx_byte); else n_pass++;
      step();
      tx_done_tick = 1'b1; wr_en = 1'b1; wr_data = 32'hCAFEF00D;
      step();
      tx_done_tick = 1'b0; wr_en = 1'b0;
      n_checks++; if (tx_start !== 1'b1) $display("FAIL b2b_start: got %b want 1", tx_start); else n_pass++;
      n_checks++; if (tx_byte !== 8'h91) $display("FAIL b2b_byte: got %h want 91", tx_byte); else n_pass++;
      n_checks++; if (level !== 3'd4 || full !== 1'b1) $display("FAIL sim_level: got level=%0d full=%b want 4/1", level, full); else n_pass++;
      n_checks++; if (overflow !== 1'b0) $display("FAIL sim_ovf: got %b want 0", overflow); else n_pass++;
      for (int k = 9; k < 13; k++)
         for (int j = 0; j < 4; j++) exp_q.push_back({4'(k), 4'(j + 1)});
      exp_q.push_back(8'hCA); exp_q.push_back(8'hFE); exp_q.push_back(8'hF0); exp_q.push_back(8'h0D);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         serve_byte(1, ok, s, t);
         n_checks++;
         if (!ok || s !== e || t !== e) $display("FAIL sim_drain: got start=%h tick=%h ok=%0d want %h", s, t, ok, e);
         else n_pass++;
      end
      n_checks++; if (busy !== 1'b0) $display("FAIL sim_busy: got %b want 0", busy); else n_pass++;
      n_checks++;
      if (start_cnt - s0 !== 24) $display("FAIL sim_starts: got %0d want 24", start_cnt - s0); else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit ok; logic [7:0] s, t, e; int s1;
      do_reset();
      wr_en = 1'b1;
      wr_data = 32'h0A0B0C0D; step();
      wr_data = 32'h1A1B1C1D; step();
      wr_data = 32'h2A2B2C2D; step();
      wr_en = 1'b0;
      n_checks++; if (tx_byte !== 8'h0A) $display("FAIL mid_first: got %h want 0A", tx_byte); else n_pass++;
      tx_done_tick = 1'b1; step(); tx_done_tick = 1'b0;
      serve_byte(1, ok, s, t);
      n_checks++; if (!ok || s !== 8'h0B) $display("FAIL mid_second: got %h ok=%0d want 0B", s, ok); else n_pass++;
      rst = 1'b1;
      step();
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (level !== 3'd0) $display("FAIL mid_level: got %0d want 0", level); else n_pass++;
      n_checks++; if (tx_start !== 1'b0) $display("FAIL mid_start: got %b want 0", tx_start); else n_pass++;
      rst = 1'b0;
      s1 = start_cnt;
      repeat (30) step();
      n_checks++; if (start_cnt !== s1) $display("FAIL mid_quiet: got %0d want %0d", start_cnt, s1); else n_pass++;
      wr_data = 32'h55667788; wr_en = 1'b1; step(); wr_en = 1'b0;
      exp_q = '{8'h55, 8'h66, 8'h77, 8'h88};
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         serve_byte(2, ok, s, t);
         n_checks++;
         if (!ok || s !== e || t !== e) $display("FAIL mid_byte: got start=%h tick=%h ok=%0d want %h", s, t, ok, e);
         else n_pass++;
      end
      repeat (10) step();
      n_checks++; if (start_cnt - s1 !== 4) $display("FAIL mid_starts: got %0d want 4", start_cnt - s1); else n_pass++;
   endtask

   task automatic test_spurious();
      bit ok; logic [7:0] s, t, e; int s0;
      do_reset();
      s0 = start_cnt;
      tx_done_tick = 1'b1; step(); tx_done_tick = 1'b0;
      n_checks++; if (state_dbg !== 2'd0 || busy !== 1'b0) $display("FAIL spur_idle: got state=%0d busy=%b want 0/0", state_dbg, busy); else n_pass++;
      wr_data = 32'h99AABBCC; wr_en = 1'b1;
      step();
      wr_en = 1'b0; tx_done_tick = 1'b1;
      step();
      n_checks++; if (tx_start !== 1'b1) $display("FAIL spur_start: got %b want 1", tx_start); else n_pass++;
      step();
      tx_done_tick = 1'b0;
      n_checks++; if (tx_start !== 1'b0 || state_dbg !== 2'd2) $display("FAIL spur_wait: got start=%b state=%0d want 0/2", tx_start, state_dbg); else n_pass++;
      n_checks++; if (tx_byte !== 8'h99) $display("FAIL spur_byte0: got %h want 99", tx_byte); else n_pass++;
      repeat (2) step();
      tx_done_tick = 1'b1; step(); tx_done_tick = 1'b0;
      exp_q = '{8'hAA, 8'hBB, 8'hCC};
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         serve_byte(3, ok, s, t);
         n_checks++;
         if (!ok || s !== e || t !== e) $display("FAIL spur_byte: got start=%h tick=%h ok=%0d want %h", s, t, ok, e);
         else n_pass++;
      end
      repeat (10) step();
      n_checks++; if (start_cnt - s0 !== 4) $display("FAIL spur_starts: got %0d want 4", start_cnt - s0); else n_pass++;
   endtask

   task automatic test_word8();
      do_reset();
      c_wr_data = 8'h5A; c_wr_en = 1'b1; step();
      c_wr_data = 8'hC3; step();
      c_wr_en = 1'b0;
      n_checks++; if (c_tx_start !== 1'b1 || c_tx_byte !== 8'h5A) $display("FAIL w8_first: got start=%b byte=%h want 1/5A", c_tx_start, c_tx_byte); else n_pass++;
      n_checks++; if (c_level !== 2'd1) $display("FAIL w8_level: got %0d want 1", c_level); else n_pass++;
      step();
      c_tick = 1'b1; step(); c_tick = 1'b0;
      n_checks++; if (c_tx_start !== 1'b1 || c_tx_byte !== 8'hC3) $display("FAIL w8_b2b: got start=%b byte=%h want 1/C3", c_tx_start, c_tx_byte); else n_pass++;
      step();
      c_tick = 1'b1; step(); c_tick = 1'b0;
      n_checks++; if (c_busy !== 1'b0 || c_empty !== 1'b1) $display("FAIL w8_done: got busy=%b empty=%b want 0/1", c_busy, c_empty); else n_pass++;
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst = 1'b1;
      wr_en = 1'b0; wr_data = '0; tx_done_tick = 1'b0;
      b_wr_en = 1'b0; b_wr_data = '0; b_tick = 1'b0;
      c_wr_en = 1'b0; c_wr_data = '0; c_tick = 1'b0;
      test_reset();
      test_single_word();
      test_byte_order();
      test_overflow();
      test_simultaneous();
      test_reset_mid();
      test_spurious();
      test_word8();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
